alu_seq_muldiv: RTL and testbench

Multi-cycle 24-bit unsigned multiply/divide sequencer that sits in front of the CPU's combinational 24-bit ALU. It issues one add or subtract per cycle on the ALU operand/control ports and consumes the returned result and carry-out. This implements 24x24→48 shift-add multiply and 24/24 restoring divide. Requests arrive and results leave over valid/ready handshakes from and to the execute stage.

---
 rtl/alu_pkg.sv | 10 +
 rtl/alu_seq_muldiv.sv | 126 ++++++++++++
 tb/tb_alu_seq_muldiv.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU opcodes, request ops and sequencer state enum
package alu_pkg;
  localparam int WIDTH = 24;
  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: 24-bit shift-add multiply / restoring divide sequencer over an external ALU; divide enabled by ALU_SEQ_DIV_EN
module alu_seq_muldiv
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             out_dz,
  output logic             out_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ainvert,
  output logic             alu_bnegate,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry_out
);
  state_t state, state_n;
  logic [WIDTH-1:0] hi, lo, opnd, hi_n, lo_n;
  logic [4:0] cnt;
  logic dz_f, err_f, short_f, accept;
`ifdef ALU_SEQ_DIV_EN
  logic div_f, take;
`endif
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign short_f = dz_f || err_f;
  assign alu_ainvert = 1'b0;
  assign alu_op = ALUOP_ADD;
  // one multiply or divide step per RUN cycle through the external ALU
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_bnegate = 1'b0;
    hi_n = hi;
    lo_n = lo;
`ifdef ALU_SEQ_DIV_EN
    take = 1'b0;
`endif
    if (state == RUN && !short_f) begin
`ifdef ALU_SEQ_DIV_EN
      if (div_f) begin
        alu_a = {hi[WIDTH-2:0], lo[WIDTH-1]};
        alu_b = opnd;
        alu_bnegate = 1'b1;
        take = hi[WIDTH-1] || alu_carry_out;
        hi_n = take ? alu_result : alu_a;
        lo_n = {lo[WIDTH-2:0], take};
      end else
`endif
      begin
        alu_a = hi;
        alu_b = lo[0] ? opnd : '0;
        {hi_n, lo_n} = {alu_carry_out, alu_result, lo[WIDTH-1:1]};
      end
    end
  end
  // next-state: accept in IDLE, 24 steps or one short cycle in RUN, wait for out_ready in DONE
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? RUN : IDLE;
      RUN:  state_n = (short_f || cnt == 5'd23) ? DONE : RUN;
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // state, operand/partial registers and result latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      opnd <= '0;
      cnt <= '0;
      dz_f <= 1'b0;
      err_f <= 1'b0;
      out_hi <= '0;
      out_lo <= '0;
      out_dz <= 1'b0;
      out_err <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_f <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        hi <= '0;
        cnt <= '0;
        out_dz <= 1'b0;
        out_err <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
        div_f <= in_op == OP_DIV;
        lo <= in_op == OP_DIV ? in_a : in_b;
        opnd <= in_op == OP_DIV ? in_b : in_a;
        dz_f <= in_op == OP_DIV && in_b == '0;
        err_f <= 1'b0;
`else
        lo <= in_b;
        opnd <= in_a;
        dz_f <= 1'b0;
        err_f <= in_op == OP_DIV;
`endif
      end else if (state == RUN) begin
        hi <= hi_n;
        lo <= lo_n;
        cnt <= cnt + 5'd1;
        if (state_n == DONE) begin
          out_hi <= short_f ? (dz_f ? lo : '0) : hi_n;
          out_lo <= short_f ? (dz_f ? '1 : '0) : lo_n;
          out_dz <= dz_f;
          out_err <= err_f;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// tb_alu_seq_muldiv: random and directed jobs against an arithmetic reference model, with a behavioural ALU
module tb_alu_seq_muldiv;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_op = 1'b0, out_ready = 1'b0;
  logic [23:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_dz, out_err, alu_ainvert, alu_bnegate, alu_carry_out;
  logic [23:0] out_hi, out_lo, alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  int n_cmp = 0, n_bad = 0;

  alu_seq_muldiv dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_hi(out_hi), .out_lo(out_lo), .out_dz(out_dz), .out_err(out_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ainvert(alu_ainvert), .alu_bnegate(alu_bnegate),
    .alu_op(alu_op), .alu_result(alu_result), .alu_carry_out(alu_carry_out)
  );

  always #5 clk = ~clk;

  always_comb {alu_carry_out, alu_result} = {1'b0, alu_a} + {1'b0, alu_bnegate ? ~alu_b : alu_b} + 25'(alu_bnegate);

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic op, input logic [23:0] a, input logic [23:0] b,
                                output logic [23:0] h, output logic [23:0] l,
                                output logic dz, output logic err, output int lat);
    logic [47:0] p;
    dz = 1'b0; err = 1'b0; lat = 24;
    if (op == 1'b0) begin
      p = 48'(a) * 48'(b);
      h = p[47:24]; l = p[23:0];
    end else begin
`ifdef ALU_SEQ_DIV_EN
      if (b == 0) begin
        h = a; l = 24'hFFFFFF; dz = 1'b1; lat = 1;
      end else begin
        l = a / b; h = a % b;
      end
`else
      h = '0; l = '0; err = 1'b1; lat = 1;
`endif
    end
  endfunction

  task automatic job(input logic op, input logic [23:0] a, input logic [23:0] b, input int stall);
    logic [23:0] eh, el, sh, sl;
    logic edz, eerr;
    int elat, k;
    model(op, a, b, eh, el, edz, eerr, elat);
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    chk("idle_alu", {alu_a, alu_b}, 0);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, elat);
    chk("hi", out_hi, eh);
    chk("lo", out_lo, el);
    chk("dz", out_dz, edz);
    chk("err", out_err, eerr);
    sh = out_hi; sl = out_lo;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; in_op = ~op; in_a = $urandom; in_b = $urandom;
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_ready", in_ready, 0);
      chk("stall_hold", {out_hi, out_lo}, {sh, sl});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
  endtask

  initial begin
    logic [23:0] rb;
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_out", {out_hi, out_lo, out_dz, out_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    job(1'b0, 24'd3, 24'd5, 0);
    job(1'b0, 24'hFFFFFF, 24'hFFFFFF, 1);
    job(1'b1, 24'd100, 24'd7, 0);
    job(1'b1, 24'h800000, 24'hFFFFFF, 0);
    job(1'b1, 24'h123456, 24'h000000, 2);
    job(1'b0, 24'hABCDEF, 24'h000001, 10);
    // reset mid-run of a multiply
    @(negedge clk);
    in_valid = 1'b1; in_op = 1'b0; in_a = 24'h00F00F; in_b = 24'h0FF0F0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_out", {out_hi, out_lo, out_dz, out_err}, 0);
    chk("mid_rst_alu", {alu_a, alu_b, alu_bnegate}, 0);
    @(negedge clk);
    chk("rst_low_valid", out_valid, 0);
    rst_n = 1'b1;
    job(1'b0, 24'd2, 24'd2, 0);
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 5))
        0: rb = 24'h0;
        1: rb = 24'hFFFFFF;
        2: rb = 24'($urandom_range(1, 15));
        default: rb = 24'($urandom);
      endcase
      job(1'($urandom_range(0, 1)), 24'($urandom), rb, $urandom_range(0, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
